// File: rtl/encoder_8x3_pkg.sv
// Shared widths and code constants for the 8-to-3 priority encoder.
package encoder_8x3_pkg;

  localparam int unsigned IN_W   = 8;
  localparam int unsigned CODE_W = 3;

  localparam logic [CODE_W-1:0] CODE_0 = 3'd0;
  localparam logic [CODE_W-1:0] CODE_1 = 3'd1;
  localparam logic [CODE_W-1:0] CODE_2 = 3'd2;
  localparam logic [CODE_W-1:0] CODE_3 = 3'd3;
  localparam logic [CODE_W-1:0] CODE_4 = 3'd4;
  localparam logic [CODE_W-1:0] CODE_5 = 3'd5;
  localparam logic [CODE_W-1:0] CODE_6 = 3'd6;
  localparam logic [CODE_W-1:0] CODE_7 = 3'd7;

endpackage

// File: rtl/encoder_8x3_if.sv
// Request/result bundle between a requester and the encoder.
interface encoder_8x3_if;
  import encoder_8x3_pkg::*;

  logic              en;
  logic [IN_W-1:0]   In;
  logic [CODE_W-1:0] Y;
  logic              valid;
  logic              multi;

  modport master (output en, output In, input Y, input valid, input multi);
  modport slave  (input en, input In, output Y, output valid, output multi);

endinterface

// File: rtl/encoder_8x3_core.sv
// Combinational priority scan (bit 7 wins) plus more-than-one-bit detect.
module encoder_8x3_core
  import encoder_8x3_pkg::*;
(
  input  logic [IN_W-1:0]   In,
  input  logic              en,
  output logic [CODE_W-1:0] y_c,
  output logic              valid_c,
  output logic              multi_c
);

  logic [CODE_W-1:0] scan;
  logic [IN_W-1:0]   low_cleared;

  // Ascending scan: the last set bit seen is the most significant one.
  always_comb begin
    scan = CODE_0;
    for (int unsigned i = 0; i < IN_W; i++) begin
      if (In[i]) scan = i[CODE_W-1:0];
    end
  end

  // Clearing the lowest set bit leaves something only when two or more were set.
  assign low_cleared = In & (In - {{(IN_W-1){1'b0}}, 1'b1});

  always_comb begin
    y_c     = CODE_0;
    valid_c = 1'b0;
    multi_c = 1'b0;
    if (en) begin
      y_c     = scan;
      valid_c = |In;
      multi_c = |low_cleared;
    end
  end

endmodule

// File: rtl/encoder_8x3.sv
// Registered 8-to-3 priority encoder; outputs follow inputs by one clock.
module encoder_8x3
  import encoder_8x3_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  encoder_8x3_if.slave bus
);

  logic [CODE_W-1:0] y_d, y_q;
  logic              valid_d, valid_q;
  logic              multi_d, multi_q;

  encoder_8x3_core u_core (
    .In      (bus.In),
    .en      (bus.en),
    .y_c     (y_d),
    .valid_c (valid_d),
    .multi_c (multi_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q     <= CODE_0;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      valid_q <= valid_d;
      multi_q <= multi_d;
    end
  end

  assign bus.Y     = y_q;
  assign bus.valid = valid_q;
  assign bus.multi = multi_q;

endmodule

// File: tb/tb_encoder_8x3.sv
// Bench for encoder_8x3: directed cases, exhaustive sweep and random traffic vs a reference model.
module tb_encoder_8x3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  encoder_8x3_if bus ();

  encoder_8x3 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: index of MSB via repeated halving, multi via population count.
  task automatic model(input logic e, input logic [7:0] v,
                       output int y, output int vld, output int mul);
    int t;
    y = 0; vld = 0; mul = 0;
    if (e && v != 8'h00) begin
      t = int'(v);
      while (t > 1) begin
        t = t / 2;
        y++;
      end
      vld = 1;
      mul = ($countones(v) >= 2) ? 1 : 0;
    end
  endtask

  task automatic expect_out(input string tag, input int y, input int vld, input int mul);
    chk({tag, ".Y"},     int'(bus.Y),     y);
    chk({tag, ".valid"}, int'(bus.valid), vld);
    chk({tag, ".multi"}, int'(bus.multi), mul);
  endtask

  // Drive at negedge, let one rising edge sample, check at the following negedge.
  task automatic step(input string tag, input logic e, input logic [7:0] v);
    int y, vld, mul;
    bus.en = e;
    bus.In = v;
    @(posedge clk);
    @(negedge clk);
    model(e, v, y, vld, mul);
    expect_out(tag, y, vld, mul);
  endtask

  initial begin
    logic [7:0] v;
    bus.en = 1'b0;
    bus.In = 8'h00;

    // Reset holds outputs low even with an active request present.
    @(negedge clk);
    expect_out("rst0", 0, 0, 0);
    bus.en = 1'b1;
    bus.In = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    expect_out("rst_hold", 0, 0, 0);
    bus.en = 1'b0;
    bus.In = 8'h00;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    expect_out("rst_rel", 0, 0, 0);

    for (int unsigned k = 0; k < 8; k++) begin
      v = 8'h01 << k;
      step($sformatf("onehot%0d", k), 1'b1, v);
    end

    step("A5", 1'b1, 8'hA5);
    step("06", 1'b1, 8'h06);
    step("zero_en", 1'b1, 8'h00);
    step("dis80", 1'b0, 8'h80);

    // Mid-cycle async reset, then synchronous release.
    step("pre_rst", 1'b1, 8'h40);
    #2 rst = 1'b1;
    #1 expect_out("async_rst", 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    expect_out("rst_held", 0, 0, 0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    expect_out("post_rst", 6, 1, 0);

    for (int unsigned i = 0; i < 256; i++) begin
      v = i[7:0];
      step($sformatf("sweep%02h", v), 1'b1, v);
    end

    for (int unsigned i = 0; i < 200; i++) begin
      v = 8'($urandom);
      if ($urandom_range(3) == 0) v = 8'h01 << $urandom_range(7);
      step($sformatf("rnd%0d", i), 1'($urandom_range(4) != 0), v);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
